// File: rtl/alu_multicycle_pkg.sv
// alu_pkg: types and constants shared by the multi-cycle ALU slice.
//   alu_op_e    - 3-bit operation select carried on the opcode bus
//   alu_state_e - controller state, also exported for debug observation
//   FLAG_*      - bit positions of the status flags in the internal flag vector
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_ILL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } alu_state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;
  localparam int NUM_FLAGS  = 4;

endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: start/done request bus of the multi-cycle ALU.
// Handshake: the master raises start with opcode/a/b; the ALU samples start
// only while idle and captures opcode/a/b on that same edge, so the master may
// change them afterwards. busy is high from the cycle after acceptance through
// the done cycle. done is a one-cycle pulse; result/aux/flags are valid in that
// cycle and hold until the next done. start seen while busy is dropped, not queued.
//   master: drives start, opcode, a, b
//   slave : drives busy, done, result, aux, zero, carry, ovf, err
interface alu_multicycle_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] aux;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             err;

  modport master (
    output start, opcode, a, b,
    input  busy, done, result, aux, zero, carry, ovf, err
  );

  modport slave (
    input  start, opcode, a, b,
    output busy, done, result, aux, zero, carry, ovf, err
  );
endinterface

// File: rtl/alu_multicycle_iter_step.sv
// alu_iter_step: one combinational step of the iterative datapath.
//   i_div_mode - 0: shift-add multiply step, 1: restoring divide step
//   i_acc      - partial accumulator (product high half / partial remainder)
//   i_operand  - multiplicand (mul) or divisor (div)
//   i_bit      - current multiplier bit (mul) or next dividend bit (div)
//   o_acc      - next accumulator
//   o_bit      - product bit shifted out (mul) or quotient bit (div)
// The divide branch exists only when ALU_MULTICYCLE_DIV_EN is defined.
module alu_iter_step #(
  parameter int WIDTH = 8
) (
  input  logic             i_div_mode,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_bit
);

  // Multiply: add the multiplicand when the bit is set, then shift the
  // (WIDTH+1)-bit sum right by one; the LSB falls into the low product half.
  logic [WIDTH:0] w_add;
  assign w_add = {1'b0, i_acc} + (i_bit ? {1'b0, i_operand} : '0);

`ifdef ALU_MULTICYCLE_DIV_EN
  // Divide: shift the next dividend bit into the remainder and try to
  // subtract. The remainder is always below the divisor, so the shifted
  // value fits WIDTH+1 bits and the trial's MSB is the borrow.
  logic [WIDTH:0] w_rem;
  logic [WIDTH:0] w_trial;
  assign w_rem   = {i_acc, i_bit};
  assign w_trial = w_rem - {1'b0, i_operand};

  always_comb begin
    o_acc = w_add[WIDTH:1];
    o_bit = w_add[0];
    if (i_div_mode) begin
      if (!w_trial[WIDTH]) begin
        o_acc = w_trial[WIDTH-1:0];
        o_bit = 1'b1;
      end else begin
        o_acc = w_rem[WIDTH-1:0];
        o_bit = 1'b0;
      end
    end
  end
`else
  // No divider: divide mode is never requested; it yields zeros.
  assign o_acc = i_div_mode ? '0 : w_add[WIDTH:1];
  assign o_bit = ~i_div_mode & w_add[0];
`endif

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: parametrised sequential ALU behind a start/done handshake.
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   bus         - alu_multicycle_if.slave (start/opcode/a/b in; busy/done/
//                 result/aux/zero/carry/ovf/err out)
//   o_dbg_state - current controller state, for observation only
// Single-step ops: IDLE -> EXEC -> DONE. MUL (and DIV with b!=0) runs WIDTH
// ITER cycles, then passes through EXEC and DONE like every other op.
// Results and flags are registered when leaving DONE, together with done.
// Optional feature macro: ALU_MULTICYCLE_DIV_EN (restoring divider). When it
// is undefined, opcode 6 is treated as the illegal opcode.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_multicycle_if.slave      bus,
  output alu_state_e           o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  alu_state_e           r_state;
  alu_op_e              r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_acc;   // product high half / remainder
  logic [WIDTH-1:0]     r_lo;    // multiplier->product low / dividend->quotient
  logic [CW-1:0]        r_step;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_aux;
  logic [NUM_FLAGS-1:0] r_flags;

  alu_op_e              w_op;
  logic                 w_go_iter;
  logic                 w_div_mode;
  logic                 w_step_bit;
  logic [WIDTH-1:0]     w_acc_nxt;
  logic                 w_bit_nxt;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_res;
  logic [WIDTH-1:0]     w_aux;
  logic [NUM_FLAGS-1:0] w_flags;

  assign w_op = alu_op_e'(bus.opcode);

`ifdef ALU_MULTICYCLE_DIV_EN
  assign w_go_iter  = (w_op == OP_MUL) || ((w_op == OP_DIV) && (bus.b != '0));
  assign w_div_mode = (r_op == OP_DIV);
`else
  assign w_go_iter  = (w_op == OP_MUL);
  assign w_div_mode = 1'b0;
`endif

  // Multiply consumes the multiplier LSB-first; divide consumes the dividend MSB-first.
  assign w_step_bit = w_div_mode ? r_lo[WIDTH-1] : r_lo[0];

  alu_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_div_mode (w_div_mode),
    .i_acc      (r_acc),
    .i_operand  (w_div_mode ? r_b : r_a),
    .i_bit      (w_step_bit),
    .o_acc      (w_acc_nxt),
    .o_bit      (w_bit_nxt)
  );

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  // Result and flag selection from the captured operands / finished datapath.
  always_comb begin
    w_res   = '0;
    w_aux   = '0;
    w_flags = '0;
    case (r_op)
      OP_ADD: begin
        w_res               = w_sum[WIDTH-1:0];
        w_flags[FLAG_CARRY] = w_sum[WIDTH];
        w_flags[FLAG_OVF]   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res               = w_diff[WIDTH-1:0];
        w_flags[FLAG_CARRY] = w_diff[WIDTH];  // borrow, i.e. a < b
        w_flags[FLAG_OVF]   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_MUL: begin
        w_res             = r_lo;
        w_aux             = r_acc;
        w_flags[FLAG_OVF] = (r_acc != '0);
      end
`ifdef ALU_MULTICYCLE_DIV_EN
      OP_DIV: begin
        if (r_b == '0) begin
          w_res             = '1;
          w_aux             = r_a;
          w_flags[FLAG_ERR] = 1'b1;
        end else begin
          w_res = r_lo;
          w_aux = r_acc;
        end
      end
`endif
      default: w_flags[FLAG_ERR] = 1'b1;
    endcase
    w_flags[FLAG_ZERO] = (w_res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_step   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_aux    <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op    <= w_op;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_acc   <= '0;
            r_lo    <= (w_op == OP_MUL) ? bus.b : bus.a;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= w_go_iter ? S_ITER : S_EXEC;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_ITER: begin
          r_acc <= w_acc_nxt;
          r_lo  <= w_div_mode ? {r_lo[WIDTH-2:0], w_bit_nxt}
                              : {w_bit_nxt, r_lo[WIDTH-1:1]};
          if (r_step == CW'(WIDTH - 1)) begin
            r_step  <= '0;
            r_state <= S_EXEC;
          end else begin
            r_step  <= r_step + 1'b1;
          end
        end
        S_EXEC: r_state <= S_DONE;
        S_DONE: begin
          r_result <= w_res;
          r_aux    <= w_aux;
          r_flags  <= w_flags;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.aux     = r_aux;
  assign bus.zero    = r_flags[FLAG_ZERO];
  assign bus.carry   = r_flags[FLAG_CARRY];
  assign bus.ovf     = r_flags[FLAG_OVF];
  assign bus.err     = r_flags[FLAG_ERR];
  assign o_dbg_state = r_state;

endmodule
